bicubic_ctrl: RTL and testbench
===============================

# bicubic_ctrl

Sequencer for the 1-D bicubic engine: for each requested output pixel it fetches the 4x4 source neighbourhood from image memory and runs four horizontal engine passes (one per row) plus one vertical pass over the row results. It then returns one 8-bit interpolated pixel. It sits between the scaler's coordinate generator and the image SRAM. It is a sibling of the engine at the top level, not a wrapper around it.

## Interface
- IMG_MAX, 100: largest source width/height supported.
- CW, 7: coordinate width, ceil(log2(IMG_MAX)).
- AW, 14: memory address width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock, asynchronous and active-high. The engine shares this reset.
- req  in  1  request; accepted only when req_ready=1.
- req_ready  out  1  high in IDLE only.
- base_x, base_y  in  CW  integer source coordinate of the neighbourhood's second column/row.
- frac_x, frac_y  in  8  fractional offset t, Q0.8.
- img_w, img_h  in  CW  source dimensions, 1..IMG_MAX.
- mem_rd  out  1  read strobe.
- mem_addr  out  AW  address = y*img_w + x.
- mem_q  in  8  read data, valid the cycle after mem_rd.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_x  out  32  weight vector; lane i is [8i+7:8i].
- eng_p  out  32  pixel vector; lane i is [8i+7:8i].
- eng_finish  in  1  engine done pulse.
- eng_out  in  8  engine result, valid with eng_finish.
- pix_out  out  8  interpolated pixel, held until the next result.
- pix_valid  out  1  one-cycle pulse.

## Operation
- Accept when req && req_ready: latch all request inputs. Later changes on the request inputs are ignored until the next accept.
- Weight vector for a fraction t:
  - lane0 = 8'hFF (1.0 saturated);
  - lane1 = t;
  - lane2 = t2 = (t*t + 128) >> 8;
  - lane3 = (t2*t + 128) >> 8.
  - The vector is computed from frac_x for the horizontal passes and from frac_y for the vertical pass.
- Neighbourhood: rows base_y-1..base_y+2 (r = 0..3), columns base_x-1..base_x+2 (lanes 0..3).
- States and transitions:
  - IDLE: on accept go to FETCH.
  - FETCH: 4 cycles, issuing mem_rd for columns 0..3 of row r. Data for column c-1 is captured into the row lane during the cycle column c is issued.
  - FLUSH: 1 cycle; captures column 3.
  - H_START: pulses eng_start with eng_x = horizontal weights and eng_p = row lanes.
  - H_WAIT: on eng_finish, capture eng_out into row_buf[r]. If r<3, increment r and go to FETCH; otherwise go to V_START.
  - V_START: pulses eng_start with eng_p = row_buf[3:0] and eng_x = vertical weights.
  - V_WAIT: on eng_finish, load pix_out and go to DONE.
  - DONE: pulse pix_valid, then return to IDLE.
- eng_x and eng_p are held stable from eng_start until eng_finish.
- eng_finish outside H_WAIT/V_WAIT is ignored.
- All address arithmetic is unsigned modulo 2^AW.

## Timing
- Reset value of every output is 0, except req_ready = 1. Internal state resets to IDLE with r = 0.
- E denotes engine latency: eng_finish arrives E cycles after the eng_start cycle. The nominal engine has E = 5.
- Latency: pix_valid rises 4*(6+E) + (1+E) + 1 cycles after the accept edge, i.e. 51 cycles for E = 5.
- Throughput is one pixel per latency + 1 cycles (no overlap between requests).
- A req asserted while busy is not accepted; the requester holds it.
- Reset asserted mid-operation: immediate abort to IDLE with outputs at reset values. The engine is reset by the same rst.

## Configuration
- BICUBIC_EDGE_CLAMP_EN defined:
  - each fetch x is clamped to [0, img_w-1] and y to [0, img_h-1] (edge replication);
  - e.g. x = -1 maps to 0, x = img_w maps to img_w-1.
- BICUBIC_EDGE_CLAMP_EN undefined:
  - raw coordinates are used with no clamping;
  - the requester guarantees 1 <= base <= dim-3.

## Structure
- Shared package bicubic_pkg holds:
  - the state enum;
  - Q08_ONE = 8'hFF;
  - IMG_MAX, CW and AW;
  - the lane-packing width constant.
- Sub-module bicubic_weight_gen (combinational) takes t and returns the 32-bit weight vector. It is instantiated twice, once for frac_x and once for frac_y.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately, req_ready = 1.
- frac_x = 0 -> first eng_start has eng_x = 32'h000000FF.
- frac_x = 8'h80 -> eng_x = 32'h204080FF.
- base (5,5), img_w = 20 -> first four mem_addr values are 84, 85, 86, 87; row 3 gives 144..147.
- Stub engine with E = 5 that returns 10 + row index:
  - vertical eng_p = 32'h0D0C0B0A;
  - pix_valid arrives exactly 51 cycles after accept;
  - a req held during the run is accepted only after DONE.
- With BICUBIC_EDGE_CLAMP_EN, base (0,0), 10x10 -> row 0 addresses 0, 0, 1, 2; row 1 addresses identical.
- rst during H_WAIT of row 2 -> no pix_valid; after release a new request completes with the correct value.

Source files
------------

// File: rtl/bicubic_pkg.sv
// bicubic_pkg: shared types and constants for the bicubic sequencer.
// Holds the FSM state enum, Q0.8 one, geometry widths and the coordinate clamp helper.
package bicubic_pkg;

    localparam int IMG_MAX = 100;
    localparam int CW      = 7;
    localparam int AW      = 14;
    localparam int LANE_W  = 8;
    localparam int VEC_W   = 4 * LANE_W;

    localparam logic [7:0] Q08_ONE = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_H_START,
        S_H_WAIT,
        S_V_START,
        S_V_WAIT,
        S_DONE
    } state_e;

    // Clamp a two's-complement coordinate (CW+2 bits) into [0, dim-1].
    function automatic logic [CW+1:0] clamp_coord(
        input logic [CW+1:0] v,
        input logic [CW-1:0] dim
    );
        logic [CW+1:0] hi;
        hi = {2'b00, dim - CW'(1)};
        if (v[CW+1]) begin
            return '0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/bicubic_weight_gen.sv
// bicubic_weight_gen: combinational cubic weight vector {t^3, t^2, t, 1} in Q0.8.
// Ports: t_i (fraction, Q0.8) -> w_o (lane i at [8i+7:8i]); products rounded half-up.
module bicubic_weight_gen
    import bicubic_pkg::*;
(
    input  logic [7:0]       t_i,
    output logic [VEC_W-1:0] w_o
);

    logic [15:0] sq;
    logic [15:0] cu;
    logic [7:0]  t2;
    logic [7:0]  t3;

    // Max 255*255+128 = 65153, so 16 bits never overflow.
    assign sq = ({8'd0, t_i} * {8'd0, t_i}) + 16'd128;
    assign t2 = 8'(sq >> 8);
    assign cu = ({8'd0, t2} * {8'd0, t_i}) + 16'd128;
    assign t3 = 8'(cu >> 8);

    assign w_o = {t3, t2, t_i, Q08_ONE};

endmodule

// File: rtl/bicubic_ctrl.sv
// bicubic_ctrl: fetches a 4x4 neighbourhood, runs four horizontal and one vertical
// engine pass, returns one pixel. Ports: req/req_ready request handshake with
// base/frac/img geometry; mem_rd/mem_addr/mem_q image SRAM (1-cycle read);
// eng_start/eng_x/eng_p/eng_finish/eng_out engine; pix_out/pix_valid result.
// Option: BICUBIC_EDGE_CLAMP_EN clamps fetch coordinates to the image (edge replication).
module bicubic_ctrl
    import bicubic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    output logic             req_ready,
    input  logic [CW-1:0]    base_x,
    input  logic [CW-1:0]    base_y,
    input  logic [7:0]       frac_x,
    input  logic [7:0]       frac_y,
    input  logic [CW-1:0]    img_w,
    input  logic [CW-1:0]    img_h,
    output logic             mem_rd,
    output logic [AW-1:0]    mem_addr,
    input  logic [7:0]       mem_q,
    output logic             eng_start,
    output logic [VEC_W-1:0] eng_x,
    output logic [VEC_W-1:0] eng_p,
    input  logic             eng_finish,
    input  logic [7:0]       eng_out,
    output logic [7:0]       pix_out,
    output logic             pix_valid
);

    state_e state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;

    logic [CW-1:0] bx_q, by_q;
    logic [CW-1:0] w_q, h_q;
    logic [7:0]    fx_q, fy_q;

    logic [3:0][7:0] lane_q;
    logic [3:0][7:0] rowbuf_q;
    logic [7:0]      pix_q;
    logic            pix_valid_q;

    logic            accept;
    logic [VEC_W-1:0] wx;
    logic [VEC_W-1:0] wy;

    assign accept = (state_q == S_IDLE) && req;

    // ---------------- weight generation ----------------
    bicubic_weight_gen u_wx (
        .t_i (fx_q),
        .w_o (wx)
    );

    bicubic_weight_gen u_wy (
        .t_i (fy_q),
        .w_o (wy)
    );

    // ---------------- fetch address ----------------
    // Coordinates carry two extra bits so base-1 can go negative.
    logic [CW+1:0] x_raw, y_raw;
    logic [CW+1:0] x_f, y_f;
    logic [AW-1:0] x_ext, y_ext, w_ext;
    logic [AW-1:0] addr;

    assign x_raw = {2'b00, bx_q} + (CW+2)'(col_q) - (CW+2)'(1);
    assign y_raw = {2'b00, by_q} + (CW+2)'(row_q) - (CW+2)'(1);

`ifdef BICUBIC_EDGE_CLAMP_EN
    assign x_f = clamp_coord(x_raw, w_q);
    assign y_f = clamp_coord(y_raw, h_q);
`else
    // Requester keeps the neighbourhood inside the image; height is not needed.
    logic unused_h;
    assign unused_h = ^h_q;
    assign x_f = x_raw;
    assign y_f = y_raw;
`endif

    // Sign-extend so address wraps modulo 2^AW.
    assign x_ext = {{(AW-CW-2){x_f[CW+1]}}, x_f};
    assign y_ext = {{(AW-CW-2){y_f[CW+1]}}, y_f};
    assign w_ext = {{(AW-CW){1'b0}}, w_q};
    assign addr  = y_ext * w_ext + x_ext;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_FETCH: begin
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_H_START;
            end
            S_H_START: begin
                state_d = S_H_WAIT;
            end
            S_H_WAIT: begin
                if (eng_finish) begin
                    if (row_q == 2'd3) begin
                        state_d = S_V_START;
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_V_START: begin
                state_d = S_V_WAIT;
            end
            S_V_WAIT: begin
                if (eng_finish) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- request latch ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bx_q <= '0;
            by_q <= '0;
            fx_q <= '0;
            fy_q <= '0;
            w_q  <= '0;
            h_q  <= '0;
        end else if (accept) begin
            bx_q <= base_x;
            by_q <= base_y;
            fx_q <= frac_x;
            fy_q <= frac_y;
            w_q  <= img_w;
            h_q  <= img_h;
        end
    end

    // ---------------- datapath ----------------
    // Read data lags the strobe by one cycle, so column c-1 lands while
    // column c is issued and FLUSH picks up the last column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q      <= '0;
            rowbuf_q    <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_valid_q <= (state_q == S_DONE);
            if (state_q == S_FETCH && col_q != 2'd0) begin
                lane_q[col_q - 2'd1] <= mem_q;
            end
            if (state_q == S_FLUSH) begin
                lane_q[3] <= mem_q;
            end
            if (state_q == S_H_WAIT && eng_finish) begin
                rowbuf_q[row_q] <= eng_out;
            end
            if (state_q == S_V_WAIT && eng_finish) begin
                pix_q <= eng_out;
            end
        end
    end

    // ---------------- outputs ----------------
    // Engine operands derive from registers that do not change while the
    // pass runs, so they stay stable from start through finish.
    always_comb begin
        eng_x = '0;
        eng_p = '0;
        if (state_q == S_H_START || state_q == S_H_WAIT) begin
            eng_x = wx;
            eng_p = lane_q;
        end else if (state_q == S_V_START || state_q == S_V_WAIT) begin
            eng_x = wy;
            eng_p = rowbuf_q;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_rd    = (state_q == S_FETCH);
    assign mem_addr  = mem_rd ? addr : '0;
    assign eng_start = (state_q == S_H_START) || (state_q == S_V_START);
    assign pix_out   = pix_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_bicubic_ctrl.sv
// tb_bicubic_ctrl: directed bench for bicubic_ctrl with SRAM model (mem[a] = a[7:0])
// and a stub engine (E = 5; row passes return 10+n, vertical returns w1 + p3).
module tb_bicubic_ctrl;
    import bicubic_pkg::*;

    localparam int ENG_E = 5;

    logic             clk;
    logic             rst;
    logic             req;
    logic             req_ready;
    logic [CW-1:0]    base_x, base_y;
    logic [7:0]       frac_x, frac_y;
    logic [CW-1:0]    img_w, img_h;
    logic             mem_rd;
    logic [AW-1:0]    mem_addr;
    logic [7:0]       mem_q;
    logic             eng_start;
    logic [VEC_W-1:0] eng_x, eng_p;
    logic             eng_finish;
    logic [7:0]       eng_out;
    logic [7:0]       pix_out;
    logic             pix_valid;

    bicubic_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_ready  (req_ready),
        .base_x     (base_x),
        .base_y     (base_y),
        .frac_x     (frac_x),
        .frac_y     (frac_y),
        .img_w      (img_w),
        .img_h      (img_h),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_p      (eng_p),
        .eng_finish (eng_finish),
        .eng_out    (eng_out),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, data = low address byte.
    always @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else if (mem_rd) mem_q <= mem_addr[7:0];
    end

    // Stub engine.
    int       e_cnt;
    int       e_n;
    logic [7:0] e_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_cnt <= 0;
            e_n <= 0;
            e_res <= '0;
            eng_finish <= 1'b0;
            eng_out <= '0;
        end else begin
            eng_finish <= 1'b0;
            if (eng_start) begin
                e_cnt <= ENG_E - 1;
                e_n <= (e_n == 4) ? 0 : e_n + 1;
                e_res <= (e_n < 4) ? 8'(10 + e_n)
                                   : eng_x[15:8] + eng_p[31:24];
            end else if (e_cnt == 1) begin
                e_cnt <= 0;
                eng_finish <= 1'b1;
                eng_out <= e_res;
            end else if (e_cnt > 1) begin
                e_cnt <= e_cnt - 1;
            end
        end
    end

    // Monitors.
    int edge_no = 0;
    logic [31:0] acc_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] x_q[$];
    logic [31:0] p_q[$];
    int pv_cnt = 0;
    int pv_edge = 0;
    logic [7:0] last_pix = '0;
    logic busy = 1'b0;
    logic [31:0] hx, hp;
    int hold_err = 0;

    always @(posedge clk) begin
        edge_no <= edge_no + 1;
        if (req && req_ready && !rst) acc_q.push_back(32'(edge_no + 1));
    end

    always @(negedge clk) begin
        if (mem_rd) addr_q.push_back(32'(mem_addr));
        if (eng_start) begin
            x_q.push_back(eng_x);
            p_q.push_back(eng_p);
        end
        if (pix_valid) begin
            pv_cnt <= pv_cnt + 1;
            pv_edge <= edge_no;
            last_pix <= pix_out;
        end
        if (rst) begin
            busy <= 1'b0;
        end else if (eng_start) begin
            busy <= 1'b1;
            hx <= eng_x;
            hp <= eng_p;
        end else if (busy) begin
            if (eng_x !== hx || eng_p !== hp) hold_err <= hold_err + 1;
            if (eng_finish) busy <= 1'b0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk_idle(input string pfx);
        check({pfx, "_rdy"}, 32'(req_ready), 32'd1);
        check({pfx, "_ctl"}, 32'({mem_rd, eng_start, pix_valid}), 32'd0);
        check({pfx, "_addr"}, 32'(mem_addr), 32'd0);
        check({pfx, "_engx"}, eng_x, 32'd0);
        check({pfx, "_engp"}, eng_p, 32'd0);
        check({pfx, "_pix"}, 32'(pix_out), 32'd0);
    endtask

    task automatic set_req(input int bx, input int by, input int fx,
                           input int fy, input int w, input int h);
        base_x = CW'(bx);
        base_y = CW'(by);
        frac_x = 8'(fx);
        frac_y = 8'(fy);
        img_w  = CW'(w);
        img_h  = CW'(h);
    endtask

    task automatic wait_acc(input string tag, input int want);
        int n = 0;
        while (acc_q.size() < want && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(acc_q.size() >= want), 32'd1);
    endtask

    task automatic wait_pix(input string tag, input int prev);
        int n = 0;
        while (pv_cnt == prev && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(pv_cnt != prev), 32'd1);
    endtask

    task automatic clear_mon();
        acc_q.delete();
        addr_q.delete();
        x_q.delete();
        p_q.delete();
    endtask

    int lat;
    int pv0;

    initial begin
        rst = 1'b1;
        req = 1'b0;
        set_req(0, 0, 0, 0, 1, 1);
        repeat (2) @(negedge clk);
        #1;
        chk_idle("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_mon();

        // A: base (5,5), 20x20, frac_x 0, frac_y 0x80; req held for B.
        set_req(5, 5, 8'h00, 8'h80, 20, 20);
        req = 1'b1;
        wait_acc("acc_a", 1);
        // Inputs change after accept; A must use its latched values.
        set_req(3, 2, 8'h80, 8'h40, 20, 20);
        wait_pix("pix_a", 0);
        lat = pv_edge - int'(at(acc_q, 0));
        check("lat_a", 32'(lat), 32'd51);
        check("pix_a_val", 32'(last_pix), 32'h8D);
        check("addr_a0", at(addr_q, 0), 32'd84);
        check("addr_a1", at(addr_q, 1), 32'd85);
        check("addr_a2", at(addr_q, 2), 32'd86);
        check("addr_a3", at(addr_q, 3), 32'd87);
        check("addr_a12", at(addr_q, 12), 32'd144);
        check("addr_a15", at(addr_q, 15), 32'd147);
        check("engx_a_h", at(x_q, 0), 32'h000000FF);
        check("engp_a_h", at(p_q, 0), 32'h57565554);
        check("engx_a_v", at(x_q, 4), 32'h204080FF);
        check("engp_a_v", at(p_q, 4), 32'h0D0C0B0A);

        // B: held req accepted only once A has finished.
        wait_acc("acc_b", 2);
        req = 1'b0;
        check("gap_ab", at(acc_q, 1) - at(acc_q, 0), 32'd52);
        wait_pix("pix_b", 1);
        check("pix_b_val", 32'(last_pix), 32'h4D);
        check("addr_b0", at(addr_q, 16), 32'd22);
        check("engx_b_h", at(x_q, 5), 32'h204080FF);
        check("engp_b_h", at(p_q, 5), 32'h19181716);
        check("engx_b_v", at(x_q, 9), 32'h041040FF);
        repeat (5) @(negedge clk);
        #1;
        check("pv_pulses", 32'(pv_cnt), 32'd2);

        // Reset during H_WAIT of row 2.
        clear_mon();
        set_req(5, 5, 8'h00, 8'h80, 20, 20);
        req = 1'b1;
        wait_acc("acc_c", 1);
        req = 1'b0;
        begin
            int n = 0;
            while (x_q.size() < 3 && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("c_row2", 32'(x_q.size()), 32'd3);
        @(posedge clk);
        #3;
        check("c_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk_idle("mid");
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pv0 = pv_cnt;
        repeat (60) @(negedge clk);
        #1;
        check("c_nopix", 32'(pv_cnt), 32'(pv0));

        // D: clean request after the abort.
        clear_mon();
        set_req(5, 5, 8'h00, 8'h80, 20, 20);
        req = 1'b1;
        wait_acc("acc_d", 1);
        req = 1'b0;
        wait_pix("pix_d", pv0);
        check("pix_d_val", 32'(last_pix), 32'h8D);
        check("engp_d_v", at(p_q, 4), 32'h0D0C0B0A);
        check("addr_d0", at(addr_q, 0), 32'd84);

`ifdef BICUBIC_EDGE_CLAMP_EN
        clear_mon();
        pv0 = pv_cnt;
        set_req(0, 0, 8'h00, 8'h00, 10, 10);
        req = 1'b1;
        wait_acc("acc_e", 1);
        req = 1'b0;
        wait_pix("pix_e", pv0);
        check("clamp_a0", at(addr_q, 0), 32'd0);
        check("clamp_a1", at(addr_q, 1), 32'd0);
        check("clamp_a2", at(addr_q, 2), 32'd1);
        check("clamp_a3", at(addr_q, 3), 32'd2);
        check("clamp_a4", at(addr_q, 4), 32'd0);
        check("clamp_a5", at(addr_q, 5), 32'd0);
        check("clamp_a6", at(addr_q, 6), 32'd1);
        check("clamp_a7", at(addr_q, 7), 32'd2);
        check("clamp_p0", at(p_q, 0), 32'h02010000);
`endif

        check("hold", 32'(hold_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
